// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the fetch-stage PC sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pc_seq_pkg;

  // Sequencer FSM encoding, exposed on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } pc_state_e;

  // LEGv8 defaults: 64-bit addresses, 4-byte instructions, word alignment.
  localparam int DEF_ADDR_WIDTH = 64;
  localparam int DEF_INC        = 4;
  localparam int DEF_ALIGN_BITS = 2;

endpackage

// File: rtl/pc_incrementer.sv
// Constant adder producing addr + INC, wrapping modulo 2**WIDTH.
// Latency: combinational.
// Backpressure: none; pure function of addr.
module pc_incrementer
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_WIDTH,
  parameter int INC   = DEF_INC
) (
  input  logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] sum
);

  // Increment sized to the datapath so the carry out is simply dropped.
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  assign sum = addr + INC_W;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: PC register, IMEM handshake, redirect, halt, misalignment fault.
// Latency: redirect visible on pc one cycle after sampling; first fetch one cycle after reset release.
// Backpressure: fetch_req stays high with pc stable until fetch_ready & ~stall, or a redirect.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int                    INC          = DEF_INC,
  parameter int                    ALIGN_BITS   = DEF_ALIGN_BITS,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_ready,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  halt,
  output logic                  fetch_req,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus_inc,
  output logic                  fault,
  output logic [1:0]            state
);

  // Low address bits that must be zero for a legal fetch address.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ALIGN_BITS) - 1);

  // Elaboration-time guards against an illegal parameter set.
  if (ALIGN_BITS < 0 || ALIGN_BITS >= ADDR_WIDTH) begin : g_bad_align
    $error("pc_sequencer: ALIGN_BITS out of range");
  end
  if (INC < (1 << ALIGN_BITS) || (INC & (INC - 1)) != 0) begin : g_bad_inc
    $error("pc_sequencer: INC must be a power of two no smaller than the alignment");
  end
  if ((RESET_VECTOR & ALIGN_MASK) != '0) begin : g_bad_vector
    $error("pc_sequencer: RESET_VECTOR is misaligned");
  end

  pc_state_e             state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  fault_q;
  logic [ADDR_WIDTH-1:0] pc_next_seq;
  logic                  target_misaligned;
  logic                  accept;

  // Sequential successor, shared adder also used by the branch-target stage.
  pc_incrementer #(
    .WIDTH (ADDR_WIDTH),
    .INC   (INC)
  ) u_inc (
    .addr (pc_q),
    .sum  (pc_next_seq)
  );

  assign target_misaligned = |(redirect_target & ALIGN_MASK);

  // Only RUN presents an address; decoded straight from the state register.
  assign fetch_req = (state_q == ST_RUN);
  assign accept    = fetch_req & fetch_ready & ~stall;

  assign pc          = pc_q;
  assign pc_plus_inc = pc_next_seq;
  assign fault       = fault_q;
  assign state       = state_q;

  // Sequencer FSM with PC and sticky fault registers; redirect outranks halt, halt outranks accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VECTOR;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // One settling cycle out of reset; all requests are ignored here.
          state_q <= ST_RUN;
        end

        ST_RUN: begin
          if (redirect_valid && target_misaligned) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end else if (redirect_valid) begin
            // A taken branch wins even if the pipeline is stalled or halting.
            pc_q <= redirect_target;
          end else if (halt) begin
            state_q <= ST_HALT;
          end else if (accept) begin
            pc_q <= pc_next_seq;
          end
        end

        ST_HALT: begin
          // Only a redirect restarts fetch; halt, stall and fetch_ready are don't-cares.
          if (redirect_valid && target_misaligned) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end else if (redirect_valid) begin
            pc_q    <= redirect_target;
            state_q <= ST_RUN;
          end
        end

        ST_FAULT: begin
          // Absorbing: pc keeps the address that preceded the bad redirect for debug.
          state_q <= ST_FAULT;
        end

        default: begin
          state_q <= ST_FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  // An un-accepted, un-redirected fetch must hold its address on the next cycle.
  a_fetch_hold : assert property (
    @(posedge clk) disable iff (!rst_n)
      (fetch_req && !accept && !redirect_valid && !halt) |=> (fetch_req && $stable(pc_q))
  );

  // The fault flag and the FAULT state always agree.
  a_fault_state : assert property (
    @(posedge clk) disable iff (!rst_n)
      fault_q == (state_q == ST_FAULT)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer at ADDR_WIDTH=32, INC=4, ALIGN_BITS=2, RESET_VECTOR=0.
// Stimulus is driven on the falling edge and queues the state expected after the next rising edge.
// A monitor pops one entry 2 time units after each rising edge or reset assertion and compares.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        halt = 1'b0;
  logic        fetch_req;
  logic [31:0] pc;
  logic [31:0] pc_plus_inc;
  logic        fault;
  logic [1:0]  state;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_WIDTH   (32),
    .INC          (4),
    .ALIGN_BITS   (2),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_ready     (fetch_ready),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .fetch_req       (fetch_req),
    .pc              (pc),
    .pc_plus_inc     (pc_plus_inc),
    .fault           (fault),
    .state           (state)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] ppi;
    logic [1:0]  st;
    logic        flt;
    logic        freq;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push_exp(input string nm, input logic [31:0] e_pc,
                          input logic [1:0] e_st, input logic e_flt);
    exp_t e;
    e.name = nm;
    e.pc   = e_pc;
    e.ppi  = e_pc + 32'd4;
    e.st   = e_st;
    e.flt  = e_flt;
    e.freq = (e_st == 2'd1);
    sb.push_back(e);
  endtask

  task automatic step(input logic rs, input logic rv, input logic [31:0] tgt,
                      input logic hlt, input logic stl, input logic rdy,
                      input logic [31:0] e_pc, input logic [1:0] e_st,
                      input logic e_flt, input string nm);
    @(negedge clk);
    rst_n           = rs;
    redirect_valid  = rv;
    redirect_target = tgt;
    halt            = hlt;
    stall           = stl;
    fetch_ready     = rdy;
    push_exp(nm, e_pc, e_st, e_flt);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (pc !== e.pc || pc_plus_inc !== e.ppi || state !== e.st ||
            fault !== e.flt || fetch_req !== e.freq) begin
          bad++;
          $display("FAIL %s: got pc=%h ppi=%h st=%0d fault=%b req=%b, want pc=%h ppi=%h st=%0d fault=%b req=%b",
                   e.name, pc, pc_plus_inc, state, fault, fetch_req,
                   e.pc, e.ppi, e.st, e.flt, e.freq);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    logic [31:0] t;

    // Reset state, then release with IDLE-ignored requests (misaligned redirect, halt, stall).
    step(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0, ST_IDLE, 1'b0, "reset");
    step(1'b1, 1'b1, 32'h102, 1'b1, 1'b1, 1'b1, 32'h0, ST_RUN,  1'b0, "idle_ignore");

    // Sequential fetch: five accepts reach pc=20, pc_plus_inc=24.
    for (int k = 1; k <= 5; k++)
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'(4 * k), ST_RUN, 1'b0, "seq");

    // Stall holds pc and keeps fetch_req high.
    step(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 32'h8, ST_RUN, 1'b0, "redir_8a");
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8, ST_RUN, 1'b0, "stall_hold");
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hC, ST_RUN, 1'b0, "stall_release");

    // Memory not ready holds pc the same way.
    step(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 32'h8, ST_RUN, 1'b0, "redir_8b");
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8, ST_RUN, 1'b0, "notready_hold");
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hC, ST_RUN, 1'b0, "ready_release");

    // Redirect overrides stall and halt in the same cycle.
    step(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 32'h100, ST_RUN, 1'b0, "redirect_over");
    step(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h104, ST_RUN, 1'b0, "after_redirect");

    // Top-of-memory wrap: pc_plus_inc of 0xFFFFFFFC is 0.
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, ST_RUN, 1'b0, "wrap_top");
    step(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         ST_RUN, 1'b0, "wrap_accept");

    // Adder sweep through aligned redirect targets.
    for (int i = 0; i < 1000; i++) begin
      t = 32'(i) * 32'h9E37_79B1;
      t[1:0] = 2'b00;
      step(1'b1, 1'b1, t, 1'b0, 1'b0, 1'b1, t, ST_RUN, 1'b0, "sweep");
    end

    // Halt holds pc for 10 cycles regardless of halt/stall; aligned redirect resumes.
    step(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 32'h20, ST_RUN,  1'b0, "redir_20");
    step(1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h20, ST_HALT, 1'b0, "halt_enter");
    for (int k = 0; k < 10; k++)
      step(1'b1, 1'b0, 32'h0, 1'(k % 2), 1'(k % 3 == 0), 1'b1, 32'h20, ST_HALT, 1'b0, "halt_hold");
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h40, ST_RUN, 1'b0, "halt_resume");
    step(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h44, ST_RUN, 1'b0, "resume_accept");

    // Misaligned redirect faults and holds pc; later redirects and accepts are ignored.
    step(1'b1, 1'b1, 32'h40,  1'b0, 1'b0, 1'b1, 32'h40, ST_RUN,   1'b0, "redir_40");
    step(1'b1, 1'b1, 32'h102, 1'b0, 1'b0, 1'b1, 32'h40, ST_FAULT, 1'b1, "misalign");
    step(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 32'h40, ST_FAULT, 1'b1, "fault_ignore_redir");
    step(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h40, ST_FAULT, 1'b1, "fault_ignore_accept");

    // Asynchronous reset pulse between clock edges clears everything at once.
    @(posedge clk);
    #6;
    rst_n = 1'b0;
    push_exp("async_rst", 32'h0, ST_IDLE, 1'b0);

    // Release, then a misaligned redirect taken from HALT also faults.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, ST_RUN,   1'b0, "rst_release");
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, ST_HALT,  1'b0, "halt_again");
    step(1'b1, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, ST_FAULT, 1'b1, "halt_misalign");

    // Every queued expectation must have been consumed.
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the LEGv8 fetch stage.
- Generalises the fixed 32-bit PC+4 adder to a configurable width and increment.
- Adds a PC register, a fetch handshake with instruction memory, stall, redirect (branch/jump), halt and misalignment-fault handling.
- Sits between the branch-resolution logic and the instruction memory port.

Parameters:
- ADDR_WIDTH, 64, width of the PC and of all address ports.
- INC, 4, byte increment per sequential fetch; a power of two, at least 2**ALIGN_BITS.
- ALIGN_BITS, 2, number of low PC bits that must be zero.
- RESET_VECTOR, 0, PC value loaded on reset; must be aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_ready  in  1  instruction memory accepts the address on pc this cycle.
- stall  in  1  hold the PC; the pipeline cannot take a new instruction.
- redirect_valid  in  1  load redirect_target as the next PC.
- redirect_target  in  ADDR_WIDTH  branch/jump target address.
- halt  in  1  request to stop fetching.
- fetch_req  out  1  pc holds a valid fetch address.
- pc  out  ADDR_WIDTH  current PC, registered.
- pc_plus_inc  out  ADDR_WIDTH  pc + INC, combinational from pc.
- fault  out  1  sticky misaligned-redirect flag, registered.
- state  out  2  current FSM state, for debug.

Behaviour:
- Reset is asynchronous and active-low. While rst_n is low: pc = RESET_VECTOR, state = IDLE, fault = 0, fetch_req = 0. This applies mid-operation as well.
- FSM states:
  - IDLE (0): entered from reset; goes to RUN on the next clock unconditionally; pc held.
  - RUN (1): the only state that fetches.
  - HALT (2): fetch stopped, pc held.
  - FAULT (3): absorbing until reset.
- fetch_req = (state == RUN), decoded combinationally from registered state.
- pc_plus_inc = (pc + INC) mod 2**ADDR_WIDTH; the carry out is discarded, so the PC wraps silently.
- Accept condition: accept = fetch_req & fetch_ready & ~stall.
- Priority in RUN, highest first, evaluated at each rising edge:
  1. redirect_valid with redirect_target[ALIGN_BITS-1:0] != 0: state becomes FAULT, fault becomes 1, pc holds.
  2. redirect_valid, aligned target: pc <= redirect_target. This overrides stall, fetch_ready and halt.
  3. halt: state becomes HALT, pc holds.
  4. accept: pc <= pc_plus_inc.
  5. Otherwise: pc holds.
- HALT:
  - An aligned redirect_valid loads pc and returns the FSM to RUN.
  - A misaligned redirect goes to FAULT.
  - halt, stall and fetch_ready are ignored.
- IDLE: redirect_valid, halt and stall are ignored.
- FAULT: all inputs are ignored; pc, fault and state hold until rst_n is asserted.
- Latency:
  - A redirect is visible on pc one cycle after it is sampled.
  - fetch_req is first high one cycle after reset is released, with pc = RESET_VECTOR.
- Handshake: fetch_req does not drop while waiting on fetch_ready. The address stays stable until it is accepted or redirected.

Decomposition:
- Shared package pc_seq_pkg holds:
  - the state enum (IDLE, RUN, HALT, FAULT) with its 2-bit encoding;
  - default constants for ADDR_WIDTH, INC and ALIGN_BITS.
- Sub-module pc_incrementer: a parametrised constant adder (width, increment) producing pc_plus_inc. It is the generalised successor of the 32-bit PC+4 adder and can be reused by the branch-target stage.

Test Plan:
Bench parameters: ADDR_WIDTH=32, RESET_VECTOR=0.
1. Reset, then fetch_ready=1 and stall=0 -> one IDLE cycle with fetch_req=0 and pc=0. Then pc steps 0, 4, 8, ...; after 5 accepts pc=20 and pc_plus_inc=24. Also sweep pc and check pc_plus_inc == pc+4 for 1000 values.
2. At pc=8, stall=1 for 3 cycles -> pc=8 and fetch_req=1 throughout. Then release -> pc=12. Repeat with fetch_ready=0 instead of stall: same result.
3. redirect_valid=1, target 0x100, with stall=1 and halt=1 in the same cycle -> next pc=0x100 and state stays RUN.
4. Redirect to 0xFFFFFFFC -> pc_plus_inc=0x00000000; after one accept pc=0 and fault=0.
5. Misaligned redirect 0x102 at pc=0x40 -> fault=1, state=FAULT, pc=0x40, fetch_req=0. A later aligned redirect is ignored. Pulse rst_n low mid-cycle -> pc=0, fault=0, state=IDLE immediately.
6. Assert halt at pc=0x20 -> state=HALT, fetch_req=0, pc=0x20 held for 10 cycles. Then aligned redirect 0x40 -> state=RUN, pc=0x40, fetch_req=1.
